// File: rtl/serial_adder16.sv
// Bit-serial adder: one full_adder cell processes operands LSB first, one bit per clock.
// Result and carry-out are registered on completion and held until the next one.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic carry,
    output logic sum
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_c;
    logic               last_bit_c;
    logic               fa_carry;
    logic               fa_sum;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .carry (fa_carry),
        .sum   (fa_sum)
    );

    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c = 1'b1;
                end
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_carry;
                psum_d  = {fa_sum, psum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit_c) begin
                    state_d = DONE;
                    sum_d   = {fa_sum, psum_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                end
            end
            DONE: begin
                if (start) begin
                    load_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start in IDLE or DONE captures fresh operands
        if (load_c) begin
            state_d = SHIFT;
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder16.sv
// Self-checking bench for serial_adder16: directed scenarios plus randomized
// operands checked against a plain-arithmetic reference model.

module tb_serial_adder16;
    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;

    serial_adder16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, WIDTH+1 bits wide
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
    endfunction

    // Launch one addition from a negedge, scramble the inputs after acceptance,
    // and observe WIDTH+3 negedges. lat = negedge index of first done (-1 if none).
    task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, output int lat, output int busy_cnt,
                         output int done_cnt, output int excl_viol);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        lat = -1; busy_cnt = 0; done_cnt = 0; excl_viol = 0;
        for (int i = 1; i <= int'(WIDTH) + 3; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = i;
            end
            if (busy && done) excl_viol++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc, dc, ev;
        do_op(16'h0003, 16'h0005, 1'b0, lat, bc, dc, ev);
        checks++; if (lat !== int'(WIDTH) + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, WIDTH + 1); end
        checks++; if (bc !== int'(WIDTH)) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, WIDTH); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
        checks++; if (sum !== 16'h0008) begin errors++; $display("FAIL basic_sum got=%h exp=0008", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", cout); end
        checks++; if (ev !== 0) begin errors++; $display("FAIL basic_exclusive got=%0d exp=0", ev); end
    endtask

    task automatic test_wrap();
        int lat, bc, dc, ev;
        do_op(16'hFFFF, 16'h0001, 1'b0, lat, bc, dc, ev);
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL wrap1_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap1_cout got=%b exp=1", cout); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL wrap1_done_count got=%0d exp=1", dc); end
        do_op(16'hFFFF, 16'hFFFF, 1'b1, lat, bc, dc, ev);
        checks++; if (sum !== 16'hFFFF) begin errors++; $display("FAIL wrap2_sum got=%h exp=ffff", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap2_cout got=%b exp=1", cout); end
        checks++; if (lat !== int'(WIDTH) + 1) begin errors++; $display("FAIL wrap2_latency got=%0d exp=%0d", lat, WIDTH + 1); end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int dc = 0;
        a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= int'(WIDTH) + 3; i++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                if (lat < 0) lat = i;
            end
            if (i == 5) begin
                start = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL midstart_done_count got=%0d exp=1", dc); end
        checks++; if (lat !== int'(WIDTH) + 1) begin errors++; $display("FAIL midstart_latency got=%0d exp=%0d", lat, WIDTH + 1); end
        checks++; if (sum !== 16'h5556) begin errors++; $display("FAIL midstart_sum got=%h exp=5556", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midstart_cout got=%b exp=0", cout); end
    endtask

    task automatic test_back_to_back();
        int first_done = -1;
        int second_done = -1;
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 2 * int'(WIDTH) + 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 16'h8000; b = 16'h8000;
            end
            if (done && first_done < 0) begin
                first_done = i;
                checks++; if (sum !== 16'h0100) begin errors++; $display("FAIL b2b_sum1 got=%h exp=0100", sum); end
                checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_cout1 got=%b exp=0", cout); end
            end else if (done && second_done < 0) begin
                second_done = i;
                checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL b2b_sum2 got=%h exp=0000", sum); end
                checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_cout2 got=%b exp=1", cout); end
            end
            if (i == int'(WIDTH) + 2) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle busy=%b exp=1", busy); end
                start = 1'b0;
            end
        end
        checks++; if (first_done !== int'(WIDTH) + 1) begin errors++; $display("FAIL b2b_done1_at got=%0d exp=%0d", first_done, WIDTH + 1); end
        checks++; if (second_done !== 2 * int'(WIDTH) + 2) begin errors++; $display("FAIL b2b_done2_at got=%0d exp=%0d", second_done, 2 * WIDTH + 2); end
    endtask

    task automatic test_reset_mid();
        int dc = 0;
        int lat, bc, dc2, ev;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", cout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL midrst_spurious_done got=%0d exp=0", dc); end
        do_op(16'h0001, 16'h0001, 1'b0, lat, bc, dc2, ev);
        checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL midrst_after_sum got=%h exp=0002", sum); end
        checks++; if (lat !== int'(WIDTH) + 1) begin errors++; $display("FAIL midrst_after_latency got=%0d exp=%0d", lat, WIDTH + 1); end
    endtask

    task automatic test_random();
        int lat, bc, dc, ev;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH:0]   exp;
        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            exp = ref_add(ra, rb, rc);
            do_op(ra, rb, rc, lat, bc, dc, ev);
            checks++; if ({cout, sum} !== exp) begin errors++; $display("FAIL rand_result a=%h b=%h cin=%b got=%b_%h exp=%b_%h", ra, rb, rc, cout, sum, exp[WIDTH], exp[WIDTH-1:0]); end
            checks++; if (lat !== int'(WIDTH) + 1) begin errors++; $display("FAIL rand_latency got=%0d exp=%0d", lat, WIDTH + 1); end
            checks++; if (dc !== 1) begin errors++; $display("FAIL rand_done_count got=%0d exp=1", dc); end
            checks++; if (ev !== 0) begin errors++; $display("FAIL rand_exclusive got=%0d exp=0", ev); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
